// File: rtl/axil_rfdc_info_table.sv
// axil_rfdc_info_table: AXI4-Lite slave holding a lockable, parameter-initialised RFDC info table
// Ports: s_axi_aclk / s_axi_aresetn   clock and asynchronous active-low reset
//        s_axi_aw* / s_axi_w* / s_axi_b*  AXI4-Lite write address, data and response channels
//        s_axi_ar* / s_axi_r*            AXI4-Lite read address and data channels
// Map:   0x0 BLOCK_ID, 0x4 STATUS (NUM_ENTRIES), 0x8 CONTROL (sticky LOCK), 0xC reserved,
//        0x10 + 4*i entry i, anything above the last entry decodes to DECERR.
module axil_rfdc_info_table #(
    parameter int                        AXI_ADDR_WIDTH = 8,
    parameter int                        NUM_ENTRIES    = 16,
    parameter logic [NUM_ENTRIES*32-1:0] INIT_VALUES    = '0,
    parameter logic [31:0]               BLOCK_ID       = 32'h5246_4449,
    parameter bit                        WRITABLE       = 1'b1
) (
    input  logic                      s_axi_aclk,
    input  logic                      s_axi_aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [31:0]               s_axi_wdata,
    input  logic [3:0]                s_axi_wstrb,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [31:0]               s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready
);
    localparam int         IW     = NUM_ENTRIES > 1 ? $clog2(NUM_ENTRIES) : 1;
    localparam int         WW     = AXI_ADDR_WIDTH - 2;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    logic          aw_held;
    logic          w_held;
    logic          lock;
    logic [WW-1:0] aw_word;
    logic [31:0]   w_data;
    logic [3:0]    w_strb;
    logic [31:0]   mem [NUM_ENTRIES];
    logic [31:0]   ar_word;
    logic [31:0]   wr_word;
    logic [IW-1:0] ar_idx;
    logic [IW-1:0] wr_idx;
    logic          ar_is_ent;
    logic          wr_is_ent;
    logic [31:0]   rd_data;
    logic [1:0]    rd_resp;
    logic [1:0]    wr_resp;
    logic          commit;
    logic          ent_we;
    logic          unused_addr_lsbs;

    // Byte-lane bits of the addresses carry no information for word registers.
    assign unused_addr_lsbs = ^{s_axi_araddr[1:0], s_axi_awaddr[1:0]};

    // Readies are gated by reset so nothing handshakes while the block is held in reset.
    assign s_axi_awready = s_axi_aresetn && !aw_held && !s_axi_bvalid;
    assign s_axi_wready  = s_axi_aresetn && !w_held && !s_axi_bvalid;
    assign s_axi_arready = s_axi_aresetn && !s_axi_rvalid;

    // Decode on the full word index so addresses above the table never alias onto it.
    assign ar_word   = 32'(s_axi_araddr[AXI_ADDR_WIDTH-1:2]);
    assign wr_word   = 32'(aw_word);
    assign ar_is_ent = ar_word >= 32'd4 && ar_word < 32'(NUM_ENTRIES) + 32'd4;
    assign wr_is_ent = wr_word >= 32'd4 && wr_word < 32'(NUM_ENTRIES) + 32'd4;
    assign ar_idx    = IW'(ar_word - 32'd4);
    assign wr_idx    = IW'(wr_word - 32'd4);

    assign rd_data = ar_word == 32'd0 ? BLOCK_ID :
                     ar_word == 32'd1 ? 32'(NUM_ENTRIES) :
                     ar_word == 32'd2 ? {31'd0, lock} :
                     ar_is_ent        ? mem[ar_idx] : 32'd0;
    assign rd_resp = (ar_word < 32'd4 || ar_is_ent) ? OKAY : DECERR;

    assign wr_resp = wr_word < 32'd2   ? SLVERR :
                     wr_word < 32'd4   ? OKAY :
                     !wr_is_ent        ? DECERR :
                     (lock || !WRITABLE) ? SLVERR : OKAY;

    // A write commits once both halves are held and no response is pending.
    assign commit = aw_held && w_held && !s_axi_bvalid;
    assign ent_we = commit && wr_is_ent && !lock && WRITABLE;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_word      <= '0;
            w_data       <= '0;
            w_strb       <= '0;
            lock         <= 1'b0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= OKAY;
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= OKAY;
            for (int i = 0; i < NUM_ENTRIES; i++)
                mem[i] <= INIT_VALUES[32*i +: 32];
        end else begin
            if (s_axi_awvalid && s_axi_awready) begin
                aw_held <= 1'b1;
                aw_word <= s_axi_awaddr[AXI_ADDR_WIDTH-1:2];
            end
            if (s_axi_wvalid && s_axi_wready) begin
                w_held <= 1'b1;
                w_data <= s_axi_wdata;
                w_strb <= s_axi_wstrb;
            end
            if (commit) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= wr_resp;
                if (wr_word == 32'd2 && w_strb[0] && w_data[0])
                    lock <= 1'b1;
            end
            if (ent_we)
                for (int b = 0; b < 4; b++)
                    if (w_strb[b])
                        mem[wr_idx][8*b +: 8] <= w_data[8*b +: 8];
            if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
            end
            // Read data is captured from pre-edge state, so a same-edge commit is not visible.
            if (s_axi_arvalid && s_axi_arready) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_data;
                s_axi_rresp  <= rd_resp;
            end else if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axil_rfdc_info_table.sv
// tb_axil_rfdc_info_table: randomized and directed checks of axil_rfdc_info_table against a table model
module tb_axil_rfdc_info_table;
    localparam int N = 16;
    localparam logic [N*32-1:0] INIT = {32'hDEAD_BEEF, 384'd0, 32'hC0DE_0002, 32'd0, 32'hA5A5_0001};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [7:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [31:0] mdl [N];
    logic        mlock;

    axil_rfdc_info_table #(
        .AXI_ADDR_WIDTH(8),
        .NUM_ENTRIES(N),
        .INIT_VALUES(INIT),
        .BLOCK_ID(32'h5246_4449),
        .WRITABLE(1'b1)
    ) dut (
        .s_axi_aclk(clk),
        .s_axi_aresetn(rst_n),
        .s_axi_awaddr(awaddr),
        .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_wdata(wdata),
        .s_axi_wstrb(wstrb),
        .s_axi_wvalid(wvalid),
        .s_axi_wready(wready),
        .s_axi_bresp(bresp),
        .s_axi_bvalid(bvalid),
        .s_axi_bready(bready),
        .s_axi_araddr(araddr),
        .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_rdata(rdata),
        .s_axi_rresp(rresp),
        .s_axi_rvalid(rvalid),
        .s_axi_rready(rready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < N; i++) mdl[i] = INIT[32*i +: 32];
        mlock = 1'b0;
    endtask

    task automatic mdl_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        int w = int'(a[7:2]);
        r = 2'b00;
        d = 32'd0;
        if (w == 0) d = 32'h5246_4449;
        else if (w == 1) d = N;
        else if (w == 2) d = {31'd0, mlock};
        else if (w >= 4 && w - 4 < N) d = mdl[w-4];
        else if (w >= 4) r = 2'b11;
    endtask

    task automatic mdl_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] r);
        int w = int'(a[7:2]);
        r = 2'b00;
        if (w < 2) r = 2'b10;
        else if (w == 2) begin
            if (s[0] && d[0]) mlock = 1'b1;
        end else if (w >= 4 && w - 4 < N) begin
            if (mlock) r = 2'b10;
            else for (int b = 0; b < 4; b++) if (s[b]) mdl[w-4][8*b +: 8] = d[8*b +: 8];
        end else if (w >= 4) r = 2'b11;
    endtask

    task automatic send_aw(input logic [7:0] a);
        int n = 0;
        logic r;
        awaddr = a;
        awvalid = 1'b1;
        do begin r = awready; tick(); n++; end while (!r && n < 50);
        awvalid = 1'b0;
        check("aw_handshake", 32'(r), 32'd1);
    endtask

    task automatic send_w();
        int n = 0;
        logic r;
        wvalid = 1'b1;
        do begin r = wready; tick(); n++; end while (!r && n < 50);
        wvalid = 1'b0;
        check("w_handshake", 32'(r), 32'd1);
    endtask

    task automatic do_read(input logic [7:0] a, input int hold, output logic [31:0] d, output logic [1:0] r);
        int n = 0;
        logic ok;
        araddr = a;
        arvalid = 1'b1;
        rready = 1'b0;
        do begin ok = arready; tick(); n++; end while (!ok && n < 50);
        arvalid = 1'b0;
        check("ar_handshake", 32'(ok), 32'd1);
        check("rvalid_latency", 32'(rvalid), 32'd1);
        d = rdata;
        r = rresp;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("r_hold_valid", 32'(rvalid), 32'd1);
            check("r_hold_data", rdata, d);
            check("r_hold_resp", 32'(rresp), 32'(r));
            check("r_hold_arready", 32'(arready), 32'd0);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("r_done", 32'(rvalid), 32'd0);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int lead, input int hold, output logic [1:0] r);
        int n = 0;
        logic ra, rw;
        wdata = d;
        wstrb = s;
        bready = 1'b0;
        if (lead > 0) begin
            send_w();
            repeat (lead - 1) tick();
            send_aw(a);
        end else if (lead < 0) begin
            send_aw(a);
            repeat (-lead - 1) tick();
            send_w();
        end else begin
            awaddr = a;
            awvalid = 1'b1;
            wvalid = 1'b1;
            do begin
                ra = awready;
                rw = wready;
                tick();
                if (ra) awvalid = 1'b0;
                if (rw) wvalid = 1'b0;
                n++;
            end while ((awvalid || wvalid) && n < 50);
            check("aw_w_handshake", 32'({awvalid, wvalid}), 32'd0);
            awvalid = 1'b0;
            wvalid = 1'b0;
        end
        n = 0;
        while (!bvalid && n < 20) begin tick(); n++; end
        check("bvalid_latency", 32'(n), 32'd1);
        r = bresp;
        for (int i = 0; i < hold; i++) begin
            check("b_hold_valid", 32'(bvalid), 32'd1);
            check("b_hold_resp", 32'(bresp), 32'(r));
            check("b_hold_readies", 32'({awready, wready}), 32'd0);
            tick();
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("b_done", 32'(bvalid), 32'd0);
        check("aw_reopen", 32'(awready), 32'd1);
    endtask

    // W is held first so the AW handshake is followed by a commit edge that coincides with the AR handshake.
    task automatic write_with_read(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                                   input logic [7:0] ra, output logic [1:0] wr, output logic [31:0] rd,
                                   output logic [1:0] rr);
        wdata = d;
        wstrb = s;
        send_w();
        send_aw(a);
        araddr = ra;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("concurrent_rvalid", 32'(rvalid), 32'd1);
        check("concurrent_bvalid", 32'(bvalid), 32'd1);
        rd = rdata;
        rr = rresp;
        wr = bresp;
        rready = 1'b1;
        bready = 1'b1;
        tick();
        rready = 1'b0;
        bready = 1'b0;
    endtask

    task automatic random_ops(input int count, input bit allow_ctrl);
        logic [7:0]  a;
        logic [31:0] d, ed;
        logic [3:0]  s;
        logic [1:0]  r, er;
        for (int k = 0; k < count; k++) begin
            a = 8'($urandom_range(0, 24) * 4 + $urandom_range(0, 3));
            if (!allow_ctrl && a[7:2] == 6'd2) a = a + 8'd4;
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                mdl_write(a, d, s, er);
                do_write(a, d, s, int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 3)), r);
                check("rand_bresp", 32'(r), 32'(er));
            end else begin
                mdl_read(a, ed, er);
                do_read(a, int'($urandom_range(0, 3)), d, r);
                check("rand_rdata", d, ed);
                check("rand_rresp", 32'(r), 32'(er));
            end
        end
    endtask

    initial begin
        logic [31:0] d, ed;
        logic [1:0]  r, er, wr;
        repeat (3) tick();
        check("rst_readies", 32'({awready, wready, arready}), 32'd0);
        check("rst_valids", 32'({bvalid, rvalid}), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_resps", 32'({bresp, rresp}), 32'd0);
        rst_n = 1'b1;
        mdl_reset();
        tick();

        do_read(8'h00, 0, d, r);
        check("block_id", d, 32'h5246_4449);
        check("block_id_resp", 32'(r), 32'd0);
        do_read(8'h04, 0, d, r);
        check("status", d, 32'h0000_0010);
        do_read(8'h10, 0, d, r);
        check("entry0_init", d, 32'hA5A5_0001);
        check("entry0_resp", 32'(r), 32'd0);

        random_ops(150, 1'b0);

        // Reset while a committed write's response is pending.
        wdata = 32'h1111_2222;
        wstrb = 4'hF;
        send_w();
        send_aw(8'h18);
        tick();
        check("pre_rst_bvalid", 32'(bvalid), 32'd1);
        do_read(8'h18, 0, d, r);
        check("pre_rst_entry2", d, 32'h1111_2222);
        #2 rst_n = 1'b0;
        #1;
        check("rst_bvalid_drop", 32'(bvalid), 32'd0);
        check("rst_readies_low", 32'({awready, wready, arready}), 32'd0);
        tick();
        rst_n = 1'b1;
        mdl_reset();
        tick();
        do_read(8'h18, 0, d, r);
        check("entry2_reload", d, 32'hC0DE_0002);
        do_read(8'h08, 0, d, r);
        check("lock_after_rst", d, 32'd0);

        mdl_write(8'h14, 32'h1234_5678, 4'b0101, er);
        do_write(8'h14, 32'h1234_5678, 4'b0101, 2, 0, r);
        check("strb_write_resp", 32'(r), 32'd0);
        do_read(8'h14, 0, d, r);
        check("strb_readback", d, 32'h0034_0078);

        mdl_write(8'h1C, 32'hAAAA_5555, 4'hF, er);
        write_with_read(8'h1C, 32'hAAAA_5555, 4'hF, 8'h1C, wr, d, r);
        check("same_edge_prewrite", d, 32'd0);
        check("same_edge_bresp", 32'(wr), 32'd0);
        do_read(8'h1C, 0, d, r);
        check("same_edge_postwrite", d, 32'hAAAA_5555);

        mdl_write(8'h08, 32'd1, 4'h1, er);
        write_with_read(8'h08, 32'd1, 4'h1, 8'h08, wr, d, r);
        check("lock_same_edge_read", d, 32'd0);
        do_read(8'h08, 0, d, r);
        check("lock_set", d, 32'd1);
        do_write(8'h14, 32'hFFFF_FFFF, 4'hF, 0, 0, r);
        check("locked_bresp", 32'(r), 32'd2);
        do_read(8'h14, 0, d, r);
        check("locked_entry", d, 32'h0034_0078);
        do_write(8'h08, 32'd0, 4'hF, -1, 0, r);
        check("unlock_attempt_resp", 32'(r), 32'd0);
        do_read(8'h08, 0, d, r);
        check("lock_sticky", d, 32'd1);

        do_write(8'h00, 32'h0, 4'hF, 0, 0, r);
        check("id_write_slverr", 32'(r), 32'd2);
        do_write(8'h0C, 32'h5, 4'hF, 0, 0, r);
        check("reserved_write_okay", 32'(r), 32'd0);
        do_read(8'h50, 0, d, r);
        check("oob_rdata", d, 32'd0);
        check("oob_rresp", 32'(r), 32'd3);
        do_write(8'h50, 32'hFFFF_FFFF, 4'hF, 1, 5, r);
        check("oob_bresp", 32'(r), 32'd3);
        do_read(8'h10, 5, d, r);
        check("hold_read_data", d, 32'hA5A5_0001);

        for (int i = 0; i < N; i++) begin
            mdl_read(8'(16 + 4 * i), ed, er);
            do_read(8'(16 + 4 * i), 0, d, r);
            check("table_sweep", d, ed);
        end

        random_ops(40, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axil_rfdc_info_table.md
Name: axil_rfdc_info_table

Overview:
Parametrised AXI4-Lite slave holding the RFDC converter/channel info table directly, with no ctrlport bridge. It replaces the fixed-size info memory with N configurable 32-bit entries loaded from a parameter vector. Entries can be written at run time until software sets a sticky lock bit. Out-of-range and locked accesses return AXI error responses. It sits on the PS AXI4-Lite interconnect beside the RFDC register space.

Parameters:
AXI_ADDR_WIDTH, 8, byte address width; must cover 0x10 + 4*NUM_ENTRIES.
NUM_ENTRIES, 16, number of table entries (1..256).
INIT_VALUES, {NUM_ENTRIES*32{1'b0}}, reset contents; entry i = INIT_VALUES[32*i +: 32].
BLOCK_ID, 32'h5246_4449, constant returned at offset 0x0.
WRITABLE, 1, 0 makes entries read-only (every entry write returns SLVERR).

Ports:
s_axi_aclk  in  1  clock, all logic.
s_axi_aresetn  in  1  asynchronous active-low reset.
s_axi_awaddr  in  AXI_ADDR_WIDTH  write address.
s_axi_awvalid / s_axi_awready  in/out  1  AW handshake.
s_axi_wdata  in  32  write data.
s_axi_wstrb  in  4  byte strobes.
s_axi_wvalid / s_axi_wready  in/out  1  W handshake.
s_axi_bresp  out  2  write response.
s_axi_bvalid / s_axi_bready  out/in  1  B handshake.
s_axi_araddr  in  AXI_ADDR_WIDTH  read address.
s_axi_arvalid / s_axi_arready  in/out  1  AR handshake.
s_axi_rdata  out  32  read data.
s_axi_rresp  out  2  read response.
s_axi_rvalid / s_axi_rready  out/in  1  R handshake.

Behaviour:
- Clock and reset: one clock, s_axi_aclk. Reset s_axi_aresetn is asynchronous and active-low.
- Address map (word-aligned; awaddr/araddr[1:0] ignored):
  - 0x0 BLOCK_ID, read-only; writes give SLVERR.
  - 0x4 STATUS: [15:0] NUM_ENTRIES, [31:16] 0; read-only; writes give SLVERR.
  - 0x8 CONTROL: bit0 LOCK; set by writing 1 with wstrb[0]; write 0 has no effect; cleared only by reset; other bits read 0.
  - 0xC reserved: reads 0 / OKAY; writes ignored / OKAY.
  - 0x10 + 4*i, i < NUM_ENTRIES: entry i.
  - Any address above the last entry: DECERR; rdata 0; no state change.
- Reset values: all *valid outputs 0, bresp/rresp 0, rdata 0, LOCK 0, entries = INIT_VALUES, AW/W holding registers empty. The ready outputs are forced 0 while reset is asserted.
- Write channel:
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
  - AW and W are accepted independently, in either order or in the same cycle, and held internally.
  - On the first edge where both are held, the write commits and bvalid rises at that same edge. Latency is 1 cycle after the later handshake.
  - Commit: for each byte b with wstrb[b]=1, entry byte b = wdata byte b. wstrb=0 commits nothing but still returns OKAY.
  - Entry write with LOCK=1 or WRITABLE=0: SLVERR, entry unchanged.
  - bvalid holds with bresp stable until bready; the holds clear on the B handshake. A new AW/W is accepted from the next cycle.
- Read channel:
  - arready = !rvalid.
  - AR handshake: rdata/rresp are registered and rvalid rises next cycle.
  - rvalid, rdata and rresp are held stable until rready. Maximum throughput is one read per 2 cycles.
- Simultaneous events:
  - A read handshake on the same edge as a write commit to the same entry returns the pre-write value.
  - A read of CONTROL on the same edge as a lock commit returns LOCK=0.
  - Read and write channels never stall each other.
- Reset mid-transaction: outstanding AW/W/B/R are discarded and no partial write occurs. Entries reload INIT_VALUES and LOCK clears.
- Address decode uses word index = addr[AXI_ADDR_WIDTH-1:2]; entry index = word index - 4. No aliasing is allowed.

Test Plan:
- After reset, read 0x0, 0x4 and 0x10 (NUM_ENTRIES=16, INIT entry0=32'hA5A5_0001) -> 32'h5246_4449, 32'h0000_0010 and 32'hA5A5_0001, each with OKAY and rvalid exactly 1 cycle after the AR handshake.
- Write 0x14 = 32'h1234_5678 with wstrb=4'b0101, sending W two cycles before AW, then read back -> bvalid 1 cycle after AW, OKAY, readback 32'h0034_0078 (initial 0).
- Write 0x8 = 1, then write 0x14 = 32'hFFFF_FFFF -> second write returns SLVERR and the entry stays 32'h0034_0078. Writing 0x8 = 0 leaves LOCK reading 1.
- Read 0x50 and write 0x50 with NUM_ENTRIES=16 -> rresp and bresp are DECERR, rdata 0, no entry changes.
- Hold bready and rready low for 5 cycles with AR issued and AW/W issued -> bvalid/rvalid and data stay stable. awready, wready and arready stay 0 until the respective handshake completes.
- Assert reset while bvalid=1 after a committed write to entry 2 -> bvalid drops immediately, entry 2 rereads INIT_VALUES[95:64], LOCK reads 0.
